// File: rtl/render_frame_sequencer.sv
// Per-frame controller for the render clock domain. It runs each frame in order:
// swap, clear/start, camera pulse, then feeder kick. It also tracks rotation angles and overrun drops.
module render_frame_sequencer #(
   parameter int ANGLE_BITS     = 8,
   parameter int TIMEOUT_CYCLES = 2_000_000,
   parameter int DROP_CNT_W     = 16,
   parameter int GUARD_CYCLES   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_start,
   input  logic [2:0]            rot_en,
   input  logic                  rm_busy,
   input  logic                  feeder_busy,
   output logic                  begin_frame,
   output logic                  cam_valid,
   output logic                  feeder_begin,
   output logic                  fb_swap,
   output logic [ANGLE_BITS-1:0] ang_x,
   output logic [ANGLE_BITS-1:0] ang_y,
   output logic [ANGLE_BITS-1:0] ang_z,
   output logic                  frame_dropped,
   output logic [DROP_CNT_W-1:0] drop_count,
   output logic                  timeout,
   output logic                  seq_busy
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(GUARD_CYCLES + 2);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] GUARD_END = GW'(GUARD_CYCLES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAM,
      ST_FEED,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t                state_q, state_d;
   logic                  begin_frame_q, begin_frame_d;
   logic                  cam_valid_q, cam_valid_d;
   logic                  feeder_begin_q, feeder_begin_d;
   logic                  fb_swap_q, fb_swap_d;
   logic                  frame_dropped_q, frame_dropped_d;
   logic                  timeout_q, timeout_d;
   logic                  seq_busy_q, seq_busy_d;
   logic                  frame_valid_q, frame_valid_d;
   logic [ANGLE_BITS-1:0] ang_x_q, ang_x_d;
   logic [ANGLE_BITS-1:0] ang_y_q, ang_y_d;
   logic [ANGLE_BITS-1:0] ang_z_q, ang_z_d;
   logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
   logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
   logic [GW-1:0]         guard_cnt_q, guard_cnt_d;

   logic wait_ok;
   logic wait_tmo;
   logic frame_end;
   logic accept;
   logic drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         begin_frame_q   <= 1'b0;
         cam_valid_q     <= 1'b0;
         feeder_begin_q  <= 1'b0;
         fb_swap_q       <= 1'b0;
         frame_dropped_q <= 1'b0;
         timeout_q       <= 1'b0;
         seq_busy_q      <= 1'b0;
         frame_valid_q   <= 1'b0;
         ang_x_q         <= '0;
         ang_y_q         <= '0;
         ang_z_q         <= '0;
         drop_count_q    <= '0;
         tmo_cnt_q       <= '0;
         guard_cnt_q     <= '0;
      end else begin
         state_q         <= state_d;
         begin_frame_q   <= begin_frame_d;
         cam_valid_q     <= cam_valid_d;
         feeder_begin_q  <= feeder_begin_d;
         fb_swap_q       <= fb_swap_d;
         frame_dropped_q <= frame_dropped_d;
         timeout_q       <= timeout_d;
         seq_busy_q      <= seq_busy_d;
         frame_valid_q   <= frame_valid_d;
         ang_x_q         <= ang_x_d;
         ang_y_q         <= ang_y_d;
         ang_z_q         <= ang_z_d;
         drop_count_q    <= drop_count_d;
         tmo_cnt_q       <= tmo_cnt_d;
         guard_cnt_q     <= guard_cnt_d;
      end
   end

   // A start coinciding with WAIT completion or timeout is accepted, not dropped.
   always_comb begin
      wait_ok   = (state_q == ST_WAIT) && (guard_cnt_q >= GUARD_END) && !rm_busy && !feeder_busy;
      wait_tmo  = (state_q == ST_WAIT) && !wait_ok && (tmo_cnt_q == TMO_LAST);
      frame_end = wait_ok || wait_tmo;
      accept    = frame_start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || frame_end);
      drop      = frame_start && !accept;

      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (frame_start) state_d = ST_CAM;
         ST_CAM:           state_d = ST_FEED;
         ST_FEED:          state_d = ST_WAIT;
         ST_WAIT:          if (frame_end) state_d = frame_start ? ST_CAM : ST_DONE;
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      begin_frame_d   = accept;
      cam_valid_d     = accept;
      fb_swap_d       = accept && (frame_valid_q || frame_end);
      feeder_begin_d  = (state_q == ST_CAM);
      timeout_d       = wait_tmo;
      frame_dropped_d = drop;
      seq_busy_d      = (state_d == ST_CAM) || (state_d == ST_FEED) || (state_d == ST_WAIT);

      frame_valid_d = frame_valid_q;
      if (frame_end) frame_valid_d = 1'b1;
      if (accept)    frame_valid_d = 1'b0;

      ang_x_d = ang_x_q;
      ang_y_d = ang_y_q;
      ang_z_d = ang_z_q;
      if (accept) begin
         if (rot_en[0]) ang_x_d = ang_x_q + ANGLE_BITS'(1);
         if (rot_en[1]) ang_y_d = ang_y_q + ANGLE_BITS'(1);
         if (rot_en[2]) ang_z_d = ang_z_q + ANGLE_BITS'(1);
      end

      drop_count_d = drop_count_q;
      if (drop && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_CNT_W'(1);

      // Both WAIT counters saturate so they never wrap while the frame lingers.
      tmo_cnt_d   = tmo_cnt_q;
      guard_cnt_d = guard_cnt_q;
      if (state_q == ST_FEED) begin
         tmo_cnt_d   = '0;
         guard_cnt_d = '0;
      end else if (state_q == ST_WAIT) begin
         if (tmo_cnt_q != TMO_LAST)    tmo_cnt_d   = tmo_cnt_q + TW'(1);
         if (guard_cnt_q < GUARD_END)  guard_cnt_d = guard_cnt_q + GW'(1);
      end
   end

   assign begin_frame   = begin_frame_q;
   assign cam_valid     = cam_valid_q;
   assign feeder_begin  = feeder_begin_q;
   assign fb_swap       = fb_swap_q;
   assign frame_dropped = frame_dropped_q;
   assign timeout       = timeout_q;
   assign seq_busy      = seq_busy_q;
   assign ang_x         = ang_x_q;
   assign ang_y         = ang_y_q;
   assign ang_z         = ang_z_q;
   assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Directed bench for render_frame_sequencer: instance A uses the default timeout and counter width,
// instance B uses TIMEOUT_CYCLES=50 and DROP_CNT_W=2. Both instances share the same stimulus.
module tb_render_frame_sequencer;

   logic       clk;
   logic       rst_n;
   logic       frame_start;
   logic [2:0] rot_en;
   logic       rm_busy;
   logic       feeder_busy;

   logic        a_begin, a_cam, a_feed, a_swap, a_drop, a_tmo, a_busy;
   logic [7:0]  a_ax, a_ay, a_az;
   logic [15:0] a_dcnt;
   logic        b_begin, b_cam, b_feed, b_swap, b_drop, b_tmo, b_busy;
   logic [7:0]  b_ax, b_ay, b_az;
   logic [1:0]  b_dcnt;

   int checks;
   int failures;

   render_frame_sequencer dut_a (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .rot_en(rot_en),
      .rm_busy(rm_busy), .feeder_busy(feeder_busy),
      .begin_frame(a_begin), .cam_valid(a_cam), .feeder_begin(a_feed), .fb_swap(a_swap),
      .ang_x(a_ax), .ang_y(a_ay), .ang_z(a_az), .frame_dropped(a_drop),
      .drop_count(a_dcnt), .timeout(a_tmo), .seq_busy(a_busy)
   );

   render_frame_sequencer #(.TIMEOUT_CYCLES(50), .DROP_CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .rot_en(rot_en),
      .rm_busy(rm_busy), .feeder_busy(feeder_busy),
      .begin_frame(b_begin), .cam_valid(b_cam), .feeder_begin(b_feed), .fb_swap(b_swap),
      .ang_x(b_ax), .ang_y(b_ay), .ang_z(b_az), .frame_dropped(b_drop),
      .drop_count(b_dcnt), .timeout(b_tmo), .seq_busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic start, input logic [2:0] rot, input logic rm, input logic fb);
      frame_start = start;
      rot_en      = rot;
      rm_busy     = rm;
      feeder_busy = fb;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b0;
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      tick(2);

      // reset state
      checkOutput("rst_begin", a_begin, 0);
      checkOutput("rst_cam", a_cam, 0);
      checkOutput("rst_swap", a_swap, 0);
      checkOutput("rst_busy", a_busy, 0);
      checkOutput("rst_ang", {a_ax, a_ay, a_az}, 0);
      checkOutput("rst_dcnt", a_dcnt, 0);
      rst_n = 1'b1;
      tick(2);
      checkOutput("post_release_begin", a_begin, 0);

      // first frame after reset
      applyStimulus(1'b1, 3'b001, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b1);
      checkOutput("f1_begin", a_begin, 1);
      checkOutput("f1_cam", a_cam, 1);
      checkOutput("f1_swap", a_swap, 0);
      checkOutput("f1_ang_x", a_ax, 1);
      checkOutput("f1_ang_yz", {a_ay, a_az}, 0);
      checkOutput("f1_feed_early", a_feed, 0);
      tick(1);
      checkOutput("f1_feed", a_feed, 1);
      checkOutput("f1_begin_off", a_begin, 0);
      checkOutput("f1_seq_busy", a_busy, 1);
      tick(1);
      checkOutput("f1_feed_off", a_feed, 0);

      // busy for 100 cycles, then drain
      tick(100);
      checkOutput("busy_hold", a_busy, 1);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      tick(10);
      checkOutput("done_seq_busy", a_busy, 0);

      // next start swaps
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
      checkOutput("f2_swap", a_swap, 1);
      checkOutput("f2_begin", a_begin, 1);
      checkOutput("f2_ang_x", a_ax, 1);
      checkOutput("f2_b_swap", b_swap, 1);
      tick(1);
      checkOutput("f2_swap_off", a_swap, 0);

      // overrun: three starts while rm_busy holds WAIT
      tick(4);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 3'b111, 1'b1, 1'b0);
         tick(1);
         applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
         checkOutput($sformatf("ovr%0d_drop", i), a_drop, 1);
         checkOutput($sformatf("ovr%0d_swap", i), a_swap, 0);
         checkOutput($sformatf("ovr%0d_begin", i), a_begin, 0);
         tick(1);
         checkOutput($sformatf("ovr%0d_drop_off", i), a_drop, 0);
      end
      checkOutput("ovr_dcnt", a_dcnt, 3);
      checkOutput("ovr_b_dcnt", b_dcnt, 3);
      checkOutput("ovr_ang", {a_ax, a_ay, a_az}, 24'h010000);

      // completion and start in the same cycle
      applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
      checkOutput("sim_swap", a_swap, 1);
      checkOutput("sim_begin", a_begin, 1);
      checkOutput("sim_drop", a_drop, 0);
      checkOutput("sim_dcnt", a_dcnt, 3);
      checkOutput("sim_ang_y", a_ay, 1);
      checkOutput("sim_b_swap", b_swap, 1);

      // timeout on B at WAIT cycle 50
      tick(51);
      checkOutput("tmo_early", b_tmo, 0);
      tick(1);
      checkOutput("tmo_pulse", b_tmo, 1);
      checkOutput("tmo_a_none", a_tmo, 0);
      tick(1);
      checkOutput("tmo_off", b_tmo, 0);
      checkOutput("tmo_seq_busy", b_busy, 0);
      applyStimulus(1'b1, 3'b000, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
      checkOutput("tmo_next_swap", b_swap, 1);
      checkOutput("tmo_next_begin", b_begin, 1);
      checkOutput("tmo_a_drop", a_drop, 1);
      checkOutput("tmo_a_dcnt", a_dcnt, 4);
      tick(1);

      // five more drops: B saturates at 3
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3'b000, 1'b1, 1'b0);
         tick(1);
         applyStimulus(1'b0, 3'b000, 1'b1, 1'b0);
         tick(1);
      end
      checkOutput("sat_b_dcnt", b_dcnt, 3);
      checkOutput("sat_a_dcnt", a_dcnt, 9);

      // reset in FEED
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);
      applyStimulus(1'b1, 3'b000, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      checkOutput("rf_swap_first", a_swap, 0);
      tick(1);
      checkOutput("rf_in_feed", a_feed, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rf_feed", a_feed, 0);
      checkOutput("rf_busy", a_busy, 0);
      checkOutput("rf_dcnt", a_dcnt, 0);
      checkOutput("rf_outs", {a_begin, a_cam, a_swap, a_drop, a_tmo}, 0);
      tick(1);
      #2;
      rst_n = 1'b1;
      tick(1);
      checkOutput("rf_release_begin", a_begin, 0);
      checkOutput("rf_release_busy", a_busy, 0);

      // 256 frames with all axes enabled wrap the angles
      for (int i = 0; i < 256; i++) begin
         applyStimulus(1'b1, 3'b111, 1'b0, 1'b0);
         tick(1);
         applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
         if (i == 0) begin
            checkOutput("wrap_first_swap", a_swap, 0);
            checkOutput("wrap_first_ang", {a_ax, a_ay, a_az}, 24'h010101);
         end
         if (i == 1) checkOutput("wrap_second_swap", a_swap, 1);
         if (i == 254) checkOutput("wrap_ang_ff", {a_ax, a_ay, a_az}, 24'hffffff);
         tick(8);
      end
      checkOutput("wrap_ang_zero", {a_ax, a_ay, a_az}, 0);
      checkOutput("wrap_dcnt", a_dcnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
